// File: rtl/pipelined_adder_tree.sv
// Pipelined signed adder tree with per-neuron accumulation, saturation and optional ReLU.
// Handshake: a beat moves on in_valid && in_ready, a result on out_valid && out_ready; a stalled result freezes the whole pipe.
module pipelined_adder_tree #(
  parameter int M        = 8,
  parameter int N        = 32,
  parameter int INTBITS  = 12,
  parameter int FRACBITS = 20,
  parameter int RELU     = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic           in_last,
  output logic           in_ready,
  input  logic [N*M-1:0] operand,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   result,
  output logic           sat
);

  localparam int S = $clog2(M);
  localparam int W = N + S + 8;

  // Bit offset of tree stage k inside the flattened partial-sum register.
  function automatic int stage_off(input int k);
    int o;
    o = 0;
    for (int j = 1; j < k; j++) o += (M >> j) * (N + j);
    return o;
  endfunction

  localparam int TOT = stage_off(S + 1);
  localparam int TOP = stage_off(S);

  localparam logic signed [W-1:0] SAT_MAX = {{(W-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [W-1:0] SAT_MIN = {{(W-N+1){1'b1}}, {(N-1){1'b0}}};

  if (INTBITS + FRACBITS != N) begin : g_bad_q_format
    $error("INTBITS + FRACBITS must equal N");
  end

  logic [TOT-1:0]      tree_d, tree_q;
  logic [S-1:0]        vld_q, lst_q;
  logic signed [W-1:0] acc_q, tree_ext, final_d;
  logic                first_q, out_valid_q, sat_q, sat_d;
  logic [N-1:0]        result_q, result_d;
  logic                adv;

  assign adv       = !(out_valid_q && !out_ready);
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign sat       = sat_q;

  for (genvar k = 1; k <= S; k++) begin : g_stage
    localparam int WK = N + k;
    localparam int OK = stage_off(k);
    for (genvar i = 0; i < (M >> k); i++) begin : g_node
      logic [WK-2:0] a, b;
      if (k == 1) begin : g_leaf
        assign a = operand[N*(2*i) +: N];
        assign b = operand[N*(2*i+1) +: N];
      end else begin : g_inner
        assign a = tree_q[stage_off(k-1) + (2*i)*(WK-1) +: WK-1];
        assign b = tree_q[stage_off(k-1) + (2*i+1)*(WK-1) +: WK-1];
      end
      // One guard bit per stage keeps every partial sum exact.
      assign tree_d[OK + i*WK +: WK] = {a[WK-2], a} + {b[WK-2], b};
    end
  end

  // Partial sums are qualified by vld_q, so they need no reset.
  always_ff @(posedge clk) begin
    if (adv) tree_q <= tree_d;
  end

  assign tree_ext = {{(W-N-S){tree_q[TOP+N+S-1]}}, tree_q[TOP +: N+S]};
  assign final_d  = (first_q ? '0 : acc_q) + tree_ext;

  always_comb begin
    result_d = final_d[N-1:0];
    sat_d    = 1'b0;
    if (final_d > SAT_MAX) begin
      result_d = {1'b0, {(N-1){1'b1}}};
      sat_d    = 1'b1;
    end else if (final_d < SAT_MIN) begin
      result_d = {1'b1, {(N-1){1'b0}}};
      sat_d    = 1'b1;
    end
    if (RELU != 0 && final_d[W-1]) result_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q       <= '0;
      lst_q       <= '0;
      acc_q       <= '0;
      first_q     <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      sat_q       <= 1'b0;
    end else if (adv) begin
      vld_q[0] <= in_valid;
      lst_q[0] <= in_last;
      for (int k = 1; k < S; k++) begin
        vld_q[k] <= vld_q[k-1];
        lst_q[k] <= lst_q[k-1];
      end
      // The beat after a last beat starts a fresh neuron.
      if (vld_q[S-1]) begin
        acc_q   <= final_d;
        first_q <= lst_q[S-1];
      end
      out_valid_q <= vld_q[S-1] && lst_q[S-1];
      if (vld_q[S-1] && lst_q[S-1]) begin
        result_q <= result_d;
        sat_q    <= sat_d;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Bench for pipelined_adder_tree: table vectors, directed stall/reset/latency cases and random beats vs. an arithmetic model.
module tb_pipelined_adder_tree;
  localparam int M = 8;
  localparam int N = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid, in_last, out_ready;
  logic [N*M-1:0] operand;
  logic           in_ready, out_valid, sat;
  logic [N-1:0]   result;
  logic           in_ready0, out_valid0, sat0;
  logic [N-1:0]   result0;

  always #5 clk = ~clk;

  pipelined_adder_tree #(.M(M), .N(N), .INTBITS(12), .FRACBITS(20), .RELU(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .operand(operand), .out_valid(out_valid), .out_ready(out_ready), .result(result), .sat(sat)
  );

  pipelined_adder_tree #(.M(M), .N(N), .INTBITS(12), .FRACBITS(20), .RELU(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready0),
    .operand(operand), .out_valid(out_valid0), .out_ready(out_ready), .result(result0), .sat(sat0)
  );

  int          n_checks = 0;
  int          n_err = 0;
  int          n_out = 0;
  logic [N:0]  exp1_q[$];
  logic [N:0]  exp0_q[$];
  longint      macc = 0;
  bit          model_on = 1'b1;
  bit          rand_ordy = 1'b0;
  int          hold_cnt = 0;
  bit          held_vld = 1'b0;
  logic [N-1:0] held_res;
  logic        held_sat;
  bit          seen_ov = 1'b0;

  typedef struct packed {
    logic [1:0]        nb;
    logic [2:0][N-1:0] v;
    logic [N-1:0]      r1;
    logic              s1;
    logic [N-1:0]      r0;
    logic              s0;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [N:0] ref_result(input longint v, input bit relu);
    longint maxv, minv, r;
    bit s;
    maxv = (longint'(1) <<< (N-1)) - 1;
    minv = -(longint'(1) <<< (N-1));
    r = v;
    s = 1'b0;
    if (v > maxv) begin r = maxv; s = 1'b1; end
    else if (v < minv) begin r = minv; s = 1'b1; end
    if (relu && r < 0) r = 0;
    return {s, r[N-1:0]};
  endfunction

  task automatic model_beat(input logic [N*M-1:0] ops, input logic last);
    longint s;
    s = 0;
    for (int i = 0; i < M; i++) s += longint'($signed(ops[N*i +: N]));
    macc += s;
    if (last) begin
      exp1_q.push_back(ref_result(macc, 1'b1));
      exp0_q.push_back(ref_result(macc, 1'b0));
      macc = 0;
    end
  endtask

  // One clock cycle: drive at the falling edge, observe 1 time unit before the rising edge.
  task automatic step(input logic v, input logic l, input logic [N*M-1:0] ops, output logic acc);
    logic [N:0] e;
    in_valid = v;
    in_last  = l;
    operand  = ops;
    if (hold_cnt > 0) begin
      out_ready = 1'b0;
      hold_cnt--;
    end else if (rand_ordy) out_ready = ($urandom_range(0, 3) != 0);
    else out_ready = 1'b1;
    #4;
    if (held_vld) check("hold", {out_valid, sat, result}, {1'b1, held_sat, held_res});
    check("in_ready", in_ready, !(out_valid && !out_ready));
    seen_ov = out_valid;
    if (out_valid && out_ready) begin
      n_out++;
      if (exp1_q.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL unexpected_result: got %h expected none", result);
      end else begin
        e = exp1_q.pop_front();
        check("result_relu1", {sat, result}, e);
      end
    end
    if (out_valid0 && out_ready) begin
      if (exp0_q.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL unexpected_result0: got %h expected none", result0);
      end else begin
        e = exp0_q.pop_front();
        check("result_relu0", {sat0, result0}, e);
      end
    end
    held_vld = out_valid && !out_ready;
    held_res = result;
    held_sat = sat;
    acc = v && in_ready;
    if (acc && model_on) model_beat(ops, l);
    @(negedge clk);
  endtask

  task automatic idle();
    logic a;
    step(1'b0, 1'b0, '0, a);
  endtask

  task automatic send_beat(input logic [N*M-1:0] ops, input logic l);
    logic a;
    int tries;
    tries = 0;
    do begin
      step(1'b1, l, ops, a);
      tries++;
    end while (!a && tries < 64);
    if (!a) begin
      n_checks++; n_err++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 64 cycles");
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp1_q.size() != 0 || exp0_q.size() != 0) && t < 80) begin
      idle();
      t++;
    end
    repeat (6) idle();
    check("drain_empty", {exp1_q.size(), exp0_q.size()}, 64'd0);
  endtask

  function automatic logic [N*M-1:0] rep(input logic [N-1:0] v);
    return {M{v}};
  endfunction

  function automatic logic [N*M-1:0] rand_ops();
    logic [N*M-1:0] o;
    logic [N-1:0]   x;
    for (int i = 0; i < M; i++) begin
      if ($urandom_range(0, 7) == 0) x = $urandom;
      else x = N'($urandom_range(0, 32'h003F_FFFF)) - 32'h0020_0000;
      o[N*i +: N] = x;
    end
    return o;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, base;
    logic [N-1:0] vb;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; operand = '0; out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    #4;
    check("rst_out_valid", {out_valid, out_valid0}, 64'd0);
    check("rst_result", {result, sat}, 64'd0);
    check("rst_result0", {result0, sat0}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);

    // Latency of a single 1.0 beat
    send_beat(rep(32'h0010_0000), 1'b1);
    lat = -1;
    for (int t = 1; t <= 12; t++) begin
      idle();
      if (lat < 0 && seen_ov) lat = t;
    end
    check("latency", lat, 4);
    drain();

    // Table-driven vectors
    tbl[0] = '{nb: 2'd1, v: {32'h0, 32'h0, 32'h0010_0000}, r1: 32'h0080_0000, s1: 1'b0, r0: 32'h0080_0000, s0: 1'b0};
    tbl[1] = '{nb: 2'd2, v: {32'h0, 32'hFFF8_0000, 32'h0010_0000}, r1: 32'h0040_0000, s1: 1'b0, r0: 32'h0040_0000, s0: 1'b0};
    tbl[2] = '{nb: 2'd1, v: {32'h0, 32'h0, 32'hFFF0_0000}, r1: 32'h0, s1: 1'b0, r0: 32'hFF80_0000, s0: 1'b0};
    tbl[3] = '{nb: 2'd3, v: {32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF}, r1: 32'h7FFF_FFFF, s1: 1'b1, r0: 32'h7FFF_FFFF, s0: 1'b1};
    tbl[4] = '{nb: 2'd1, v: {32'h0, 32'h0, 32'h0}, r1: 32'h0, s1: 1'b0, r0: 32'h0, s0: 1'b0};
    tbl[5] = '{nb: 2'd2, v: {32'h0, 32'hFFFF_FFFF, 32'h0000_0001}, r1: 32'h0, s1: 1'b0, r0: 32'h0, s0: 1'b0};
    tbl[6] = '{nb: 2'd1, v: {32'h0, 32'h0, 32'hF000_0000}, r1: 32'h0, s1: 1'b0, r0: 32'h8000_0000, s0: 1'b0};
    tbl[7] = '{nb: 2'd1, v: {32'h0, 32'h0, 32'h1000_0000}, r1: 32'h7FFF_FFFF, s1: 1'b1, r0: 32'h7FFF_FFFF, s0: 1'b1};
    model_on = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp1_q.push_back({tbl[i].s1, tbl[i].r1});
      exp0_q.push_back({tbl[i].s0, tbl[i].r0});
      for (int b = 0; b < int'(tbl[i].nb); b++) begin
        vb = tbl[i].v[b];
        send_beat(rep(vb), (b == int'(tbl[i].nb) - 1));
      end
    end
    drain();
    model_on = 1'b1;

    // Back-pressure: result held while back-to-back beats keep arriving
    hold_cnt = 10;
    for (int i = 1; i <= 4; i++) send_beat(rep(32'h0008_0000 * i), 1'b1);
    send_beat(rep(32'h0003_0000), 1'b0);
    send_beat(rep(32'hFFFE_0000), 1'b1);
    drain();

    // Reset in the middle of a two-beat neuron
    send_beat(rep(32'h0010_0000), 1'b0);
    idle();
    rst = 1'b1;
    macc = 0;
    held_vld = 1'b0;
    #4;
    check("rst_mid_ov", out_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    base = n_out;
    exp1_q.push_back({1'b0, 32'h0080_0000});
    exp0_q.push_back({1'b0, 32'h0080_0000});
    model_on = 1'b0;
    send_beat(rep(32'h0010_0000), 1'b1);
    drain();
    check("rst_outputs", n_out - base, 1);
    model_on = 1'b1;

    // Random beats, bubbles and back-pressure
    rand_ordy = 1'b1;
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      else send_beat(rand_ops(), ($urandom_range(0, 2) == 0));
    end
    send_beat(rand_ops(), 1'b1);
    rand_ordy = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/pipelined_adder_tree.md
PIPELINED_ADDER_TREE -- requirements
Module: pipelined_adder_tree

Interface
REQ-001 SHALL have parameter M, default 8, number of operands per beat (power of two, 2..64).
REQ-002 SHALL have parameter N, default 32, operand and result width (signed two's complement).
REQ-003 SHALL have parameter INTBITS, default 12, integer bits of the Q format.
REQ-004 SHALL have parameter FRACBITS, default 20, fraction bits; INTBITS+FRACBITS SHALL equal N.
REQ-005 SHALL have parameter RELU, default 1; when 1, negative final results are clamped to 0.
REQ-006 SHALL have ports:
- clk  input  1  rising-edge clock, the only clock in the block.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat present.
- in_last  input  1  final beat of the current neuron.
- in_ready  output  1  beat accepted when in_valid && in_ready.
- operand  input  N*M  M signed operands; operand i at bits [N*(i+1)-1 -: N].
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- result  output  N  saturated, optionally ReLU'd sum.
- sat  output  1  result was clipped by saturation (not by ReLU).

Function
REQ-007 SHALL sum the M operands in a binary tree of S = log2(M) registered stages; stage k SHALL carry M/2^k partial sums of width N+k, sign-extended, with no truncation.
REQ-008 SHALL follow the tree with one accumulate stage holding a signed accumulator of width W = N+S+8.
REQ-009 SHALL advance a valid bit with each tree stage.
REQ-010 SHALL load the accumulator with the tree sum on the first beat of a neuron, and add the tree sum on each later beat.
REQ-011 SHALL treat the beat after an in_last beat as a first beat; after reset, the first beat SHALL be a first beat.
REQ-012 SHALL, on an in_last beat leaving the tree, compute the final value as the accumulator plus the tree sum.
REQ-013 SHALL saturate that final value to [-2^(N-1), 2^(N-1)-1].
REQ-014 SHALL then, if RELU=1, replace a negative value with 0.
REQ-015 SHALL register the value into result, assert out_valid, and set sat = 1 when saturation changed the value.
REQ-016 SHALL NOT assert out_valid for non-last beats.
REQ-017 SHALL have a latency of S+1 cycles from an accepted in_last beat to out_valid (M=8: 4 cycles) with no stall.
REQ-018 SHALL sustain a throughput of one beat per cycle.
REQ-019 SHALL, when out_valid && !out_ready, freeze every pipeline register, valid bit and the accumulator.
REQ-020 SHALL drive in_ready = !(out_valid && !out_ready) combinationally.
REQ-021 SHALL hold result and sat stable while out_valid && !out_ready.
REQ-022 SHALL deassert out_valid on the handshake cycle unless a new result is loaded in that same cycle.
REQ-023 SHALL NOT let bubble cycles (in_valid=0) change the accumulator.
REQ-024 SHALL apply no rounding; the Q format is bookkeeping only, and sums are exact until saturation.

Reset
REQ-025 SHALL, while rst=1, asynchronously clear all valid bits, the accumulator, result (0), sat (0) and out_valid (0), and set the first-beat flag.
REQ-026 SHALL discard any partially accumulated neuron when reset is asserted mid-operation; no out_valid SHALL follow for it.
REQ-027 SHALL have in_ready = 1 immediately after reset release.

Verification
REQ-028 All eight operands 0x00100000 (1.0), in_last=1, out_ready=1 -> out_valid 4 cycles later, result 0x00800000, sat=0.
REQ-029 Beat 1: operands 0x00100000, in_last=0; beat 2: operands 0xFFF80000 (-0.5), in_last=1 -> single out_valid, result 0x00400000.
REQ-030 RELU=1, all operands 0xFFF00000, in_last=1 -> result 0x00000000, sat=0; with RELU=0 -> result 0xFF800000.
REQ-031 All operands 0x7FFFFFFF for 3 beats, last on beat 3 -> result 0x7FFFFFFF, sat=1.
REQ-032 out_ready=0 for 5 cycles with a result pending and back-to-back beats -> in_ready=0, result held, no beat lost, results emitted in order after release.
REQ-033 rst pulsed after beat 1 of a 2-beat neuron, then a fresh 1-beat neuron of 1.0 operands -> only result 0x00800000 appears.
